// File: rtl/pattern_scan_scheduler.sv
// rtl/pattern_scan_scheduler.sv - time-multiplexes one 8-bit compare array over NSLOT pattern slots
// Optional HIT_COUNT_EN adds per-slot saturating hit counters with cnt_sel/cnt_out.
module pattern_scan_scheduler #(
   parameter int NSLOT = 4,
   parameter int SW    = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic             din,
   input  logic             din_valid,
   output logic             din_ready,
   input  logic             cfg_we,
   output logic             cfg_ready,
   input  logic [SW-1:0]    cfg_slot,
   input  logic [7:0]       cfg_pat,
   input  logic [3:0]       cfg_len,
   output logic [7:0]       det_a,
   output logic [7:0]       det_b,
   input  logic [7:0]       det_cmp,
   output logic             hit_valid,
   output logic [SW-1:0]    hit_id,
   output logic [NSLOT-1:0] hit_flags,
   input  logic [NSLOT-1:0] hit_clr,
`ifdef HIT_COUNT_EN
   input  logic [SW-1:0]    cnt_sel,
   output logic [7:0]       cnt_out,
`endif
   output logic             busy
);

   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN} state_t;

   state_t           r_state;
   logic [SW-1:0]    r_idx;
   logic [7:0]       r_window;
   logic [7:0]       r_pat [NSLOT];
   logic [3:0]       r_len [NSLOT];
   logic             r_pv;
   logic [SW-1:0]    r_pid;
   logic [7:0]       r_hold;
   logic             r_hold_vld;
   logic             r_hit_valid;
   logic [SW-1:0]    r_hit_id;
   logic [NSLOT-1:0] r_flags;

   logic [7:0]       w_cmp;
   logic [3:0]       w_len;
   logic [7:0]       w_mask;
   logic             w_match;
   logic [NSLOT-1:0] w_set;
   logic             w_idle;

   // While frozen, the array keeps answering for the held presentation, so the
   // result owed to the pending slot is parked in r_hold until ena returns.
   assign w_cmp   = r_hold_vld ? r_hold : det_cmp;
   assign w_len   = r_len[r_pid];
   assign w_mask  = ~(8'hFF << w_len);
   assign w_match = r_pv && (w_len != 4'd0) && (w_len <= 4'd8) && ((w_cmp | ~w_mask) == 8'hFF);

   always_comb begin
      w_set = '0;
      if (w_match) w_set[r_pid] = 1'b1;
   end

   assign w_idle    = (r_state == S_IDLE);
   assign din_ready = w_idle & ena;
   assign cfg_ready = w_idle & ena;
   assign busy      = ~w_idle;
   assign det_a     = r_window;
   assign det_b     = r_pat[r_idx];
   assign hit_valid = r_hit_valid;
   assign hit_id    = r_hit_id;
   assign hit_flags = r_flags;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_idx       <= '0;
         r_window    <= 8'd0;
         for (int i = 0; i < NSLOT; i++) begin
            r_pat[i] <= 8'd0;
            r_len[i] <= 4'd0;
         end
         r_pv        <= 1'b0;
         r_pid       <= '0;
         r_hold      <= 8'd0;
         r_hold_vld  <= 1'b0;
         r_hit_valid <= 1'b0;
         r_hit_id    <= '0;
         r_flags     <= '0;
      end else if (ena) begin
         case (r_state)
            S_IDLE: begin
               if (cfg_we) begin
                  r_pat[cfg_slot] <= cfg_pat;
                  r_len[cfg_slot] <= cfg_len;
               end
               if (din_valid) begin
                  r_window <= {r_window[6:0], din};
                  r_idx    <= '0;
                  r_state  <= S_SCAN;
               end
            end
            S_SCAN: begin
               r_idx <= r_idx + 1'b1;
               if (r_idx == SW'(NSLOT - 1)) r_state <= S_DRAIN;
            end
            S_DRAIN: r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
         r_pv        <= (r_state == S_SCAN);
         r_pid       <= r_idx;
         r_hold_vld  <= 1'b0;
         r_hit_valid <= w_match;
         if (w_match) r_hit_id <= r_pid;
         r_flags     <= (r_flags & ~hit_clr) | w_set;
      end else begin
         r_hit_valid <= 1'b0;
         if (r_pv && !r_hold_vld) begin
            r_hold     <= det_cmp;
            r_hold_vld <= 1'b1;
         end
      end
   end

`ifdef HIT_COUNT_EN
   logic [7:0] r_cnt [NSLOT];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NSLOT; i++) r_cnt[i] <= 8'd0;
      end else if (ena) begin
         for (int i = 0; i < NSLOT; i++) begin
            if (w_set[i]) begin
               if (hit_clr[i])             r_cnt[i] <= 8'd1;
               else if (r_cnt[i] != 8'hFF) r_cnt[i] <= r_cnt[i] + 8'd1;
            end else if (hit_clr[i]) begin
               r_cnt[i] <= 8'd0;
            end
         end
      end
   end

   assign cnt_out = r_cnt[cnt_sel];
`endif

endmodule

// File: tb/tb_pattern_scan_scheduler.sv
// tb/tb_pattern_scan_scheduler.sv - scoreboard bench for pattern_scan_scheduler
module tb_pattern_scan_scheduler;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ena;
   logic       din;
   logic       din_valid;
   logic       din_ready;
   logic       cfg_we;
   logic       cfg_ready;
   logic [1:0] cfg_slot;
   logic [7:0] cfg_pat;
   logic [3:0] cfg_len;
   logic [7:0] det_a;
   logic [7:0] det_b;
   logic [7:0] det_cmp = 8'd0;
   logic       hit_valid;
   logic [1:0] hit_id;
   logic [3:0] hit_flags;
   logic [3:0] hit_clr;
   logic       busy;
`ifdef HIT_COUNT_EN
   logic [1:0] cnt_sel;
   logic [7:0] cnt_out;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   typedef struct {
      int cyc;
      int id;
   } exp_t;
   exp_t q[$];

   logic [7:0] m_window;
   logic [7:0] m_pat [4];
   logic [3:0] m_len [4];

   pattern_scan_scheduler #(.NSLOT(4), .SW(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ena       (ena),
      .din       (din),
      .din_valid (din_valid),
      .din_ready (din_ready),
      .cfg_we    (cfg_we),
      .cfg_ready (cfg_ready),
      .cfg_slot  (cfg_slot),
      .cfg_pat   (cfg_pat),
      .cfg_len   (cfg_len),
      .det_a     (det_a),
      .det_b     (det_b),
      .det_cmp   (det_cmp),
      .hit_valid (hit_valid),
      .hit_id    (hit_id),
      .hit_flags (hit_flags),
      .hit_clr   (hit_clr),
`ifdef HIT_COUNT_EN
      .cnt_sel   (cnt_sel),
      .cnt_out   (cnt_out),
`endif
      .busy      (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Compare array: registered XNOR of window and pattern
   always @(posedge clk) det_cmp <= ~(det_a ^ det_b);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_tests++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (q.size() > 0 && q[0].cyc == cyc) begin
            chk("hit_valid", {31'd0, hit_valid}, 32'd1);
            chk("hit_id", {30'd0, hit_id}, q[0].id);
            void'(q.pop_front());
         end else begin
            chk("no_hit", {31'd0, hit_valid}, 32'd0);
         end
      end
   end

   task automatic wait_cyc(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic model_reset();
      m_window = 8'd0;
      for (int i = 0; i < 4; i++) begin
         m_pat[i] = 8'd0;
         m_len[i] = 4'd0;
      end
   endtask

   task automatic send_bit(input logic b, input int shift, output int t);
      int  w;
      logic match;
      w = 0;
      while (!din_ready && w < 40) begin
         @(negedge clk);
         w++;
      end
      if (!din_ready) chk("din_ready_timeout", {31'd0, din_ready}, 32'd1);
      din       = b;
      din_valid = 1'b1;
      t         = cyc;
      m_window  = {m_window[6:0], b};
      for (int i = 0; i < 4; i++) begin
         match = (m_len[i] >= 4'd1) && (m_len[i] <= 4'd8);
         for (int k = 0; k < 8; k++)
            if (k < int'(m_len[i]) && m_window[k] != m_pat[i][k]) match = 1'b0;
         if (match) q.push_back('{t + 3 + i + shift, i});
      end
      @(negedge clk);
      din_valid = 1'b0;
   endtask

   task automatic cfg(input logic [1:0] slot, input logic [7:0] pat, input logic [3:0] len);
      int w;
      w = 0;
      while (!cfg_ready && w < 40) begin
         @(negedge clk);
         w++;
      end
      if (!cfg_ready) chk("cfg_ready_timeout", {31'd0, cfg_ready}, 32'd1);
      cfg_we   = 1'b1;
      cfg_slot = slot;
      cfg_pat  = pat;
      cfg_len  = len;
      m_pat[slot] = pat;
      m_len[slot] = len;
      @(negedge clk);
      cfg_we = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL global_timeout cycles=%0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      int t;
      rst_n = 1'b0; ena = 1'b1; din = 1'b0; din_valid = 1'b0;
      cfg_we = 1'b0; cfg_slot = 2'd0; cfg_pat = 8'd0; cfg_len = 4'd0; hit_clr = 4'd0;
`ifdef HIT_COUNT_EN
      cnt_sel = 2'd0;
`endif
      model_reset();
      repeat (3) @(negedge clk);
      chk("rst_din_ready", {31'd0, din_ready}, 32'd1);
      chk("rst_cfg_ready", {31'd0, cfg_ready}, 32'd1);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_hit_valid", {31'd0, hit_valid}, 32'd0);
      chk("rst_hit_id", {30'd0, hit_id}, 32'd0);
      chk("rst_hit_flags", {28'd0, hit_flags}, 32'd0);
      chk("rst_det_a", {24'd0, det_a}, 32'd0);
      chk("rst_det_b", {24'd0, det_b}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_busy", {31'd0, busy}, 32'd0);

      // All slots disabled: no hits, fixed 6-cycle turnaround
      send_bit(1'b1, 0, t);
      chk("det_a_shift", {24'd0, det_a}, 32'h01);
      chk("scan_ready_low", {31'd0, din_ready}, 32'd0);
      chk("scan_busy", {31'd0, busy}, 32'd1);
      wait_cyc(t + 5);
      chk("drain_ready_low", {31'd0, din_ready}, 32'd0);
      wait_cyc(t + 6);
      chk("ready_return", {31'd0, din_ready}, 32'd1);
      chk("idle_busy2", {31'd0, busy}, 32'd0);

      // Slot 2 = 101, len 3
      cfg(2'd2, 8'b0000_0101, 4'd3);
      send_bit(1'b1, 0, t);
      send_bit(1'b0, 0, t);
      send_bit(1'b1, 0, t);
      wait_cyc(t + 6);
      chk("flags_slot2", {28'd0, hit_flags}, 32'b0100);

      // Slot 0 = FF len 8, slot 3 = 1 len 1, eight ones
      cfg(2'd0, 8'hFF, 4'd8);
      cfg(2'd3, 8'h01, 4'd1);
      for (int i = 0; i < 8; i++) send_bit(1'b1, 0, t);
      wait_cyc(t + 7);
      chk("flags_0_2_3", {28'd0, hit_flags}, 32'b1101);

      // hit_clr vs simultaneous set, then clear a cycle later
      hit_clr = 4'hF;
      @(negedge clk);
      hit_clr = 4'h0;
      chk("flags_cleared", {28'd0, hit_flags}, 32'd0);
      cfg(2'd2, 8'h01, 4'd1);
      send_bit(1'b1, 0, t);
      wait_cyc(t + 4);
      hit_clr = 4'b0100;
      wait_cyc(t + 5);
      chk("clr_same_cycle", {31'd0, hit_flags[2]}, 32'd1);
      wait_cyc(t + 6);
      hit_clr = 4'b0000;
      chk("clr_next_cycle", {28'd0, hit_flags}, 32'b1001);

      // Table write during SCAN must be ignored
      send_bit(1'b1, 0, t);
      wait_cyc(t + 2);
      cfg_we = 1'b1; cfg_slot = 2'd1; cfg_pat = 8'h01; cfg_len = 4'd1;
      chk("cfg_ready_scan", {31'd0, cfg_ready}, 32'd0);
      @(negedge clk);
      cfg_we = 1'b0;
      send_bit(1'b1, 0, t);
      wait_cyc(t + 6);
      chk("slot1_not_written", {31'd0, hit_flags[1]}, 32'd0);

      // ena low three cycles mid-scan: every hit shifts by 3
      send_bit(1'b1, 3, t);
      wait_cyc(t + 2);
      ena = 1'b0;
      chk("freeze_busy", {31'd0, busy}, 32'd1);
      chk("freeze_ready", {31'd0, din_ready}, 32'd0);
      wait_cyc(t + 5);
      ena = 1'b1;
      wait_cyc(t + 8);
      chk("freeze_ready_late", {31'd0, din_ready}, 32'd0);
      wait_cyc(t + 9);
      chk("freeze_ready_back", {31'd0, din_ready}, 32'd1);

      // Reset in the middle of a scan
      send_bit(1'b1, 0, t);
      wait_cyc(t + 2);
      rst_n = 1'b0;
      q.delete();
      model_reset();
      #1;
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      chk("mid_rst_flags", {28'd0, hit_flags}, 32'd0);
      chk("mid_rst_hit_valid", {31'd0, hit_valid}, 32'd0);
      chk("mid_rst_hit_id", {30'd0, hit_id}, 32'd0);
      chk("mid_rst_det_a", {24'd0, det_a}, 32'd0);
      chk("mid_rst_det_b", {24'd0, det_b}, 32'd0);
      chk("mid_rst_ready", {31'd0, din_ready}, 32'd1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      send_bit(1'b1, 0, t);
      wait_cyc(t + 7);
      chk("post_rst_flags", {28'd0, hit_flags}, 32'd0);

`ifdef HIT_COUNT_EN
      cfg(2'd1, 8'h01, 4'd1);
      cnt_sel = 2'd1;
      for (int i = 0; i < 300; i++) send_bit(1'b1, 0, t);
      wait_cyc(t + 7);
      chk("cnt_saturate", {24'd0, cnt_out}, 32'd255);
      cnt_sel = 2'd0;
      #1;
      chk("cnt_slot0", {24'd0, cnt_out}, 32'd0);
`endif

      chk("queue_empty", q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pattern_scan_scheduler.md
# pattern_scan_scheduler

Time-multiplexes one shared 8-bit bit-compare array across NSLOT stored pattern slots, so a single neuron comparator bank detects up to NSLOT patterns of individual length 1–8 in one serial stream. Owns the serial input window, the pattern/length table and the length masking. Sequences a per-bit scan of every slot and reports per-slot hits. Sits between the serial source (valid/ready) and the compare array, whose outputs are registered.

## Interface
Parameters:
- NSLOT, 4, number of pattern slots (power of two, 2–8)
- SW, 2, slot index width, = log2(NSLOT)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  global enable; low freezes FSM, table, window, counters
- din  in  1  serial stream bit
- din_valid  in  1  din qualifier
- din_ready  out  1  = (state==IDLE) & ena
- cfg_we  in  1  table write strobe, honored only when cfg_ready
- cfg_ready  out  1  = (state==IDLE) & ena
- cfg_slot  in  SW  slot to write
- cfg_pat  in  8  pattern; bit 0 = most recent stream bit
- cfg_len  in  4  pattern length; 0 or >8 disables slot
- det_a  out  8  window to compare array
- det_b  out  8  pattern of slot under scan
- det_cmp  in  8  per-bit equality from array, valid 1 cycle after det_a/det_b
- hit_valid  out  1  one-cycle pulse: slot hit_id matched
- hit_id  out  SW  slot index of this pulse
- hit_flags  out  NSLOT  sticky per-slot hit flags
- hit_clr  in  NSLOT  per-bit clear of hit_flags
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, SCAN, DRAIN.
- IDLE: din_valid & din_ready accepts a bit: window <= {window[6:0], din}; scan index <= 0; -> SCAN. cfg_we & cfg_ready writes pat/len to cfg_slot. Both may occur in one cycle; the write applies before the first slot of that scan is presented.
- SCAN: det_a = window, det_b = table[idx].pat; idx increments each cycle; after idx==NSLOT-1 -> DRAIN.
- DRAIN: one cycle collecting the last slot's det_cmp; -> IDLE.
- Match eval on the registered det_cmp for slot i: len in 1..8 and det_cmp[len-1:0] all ones. Otherwise no match.
- All slots are scanned every bit, including disabled ones, so latency is fixed.
- Match registers: hit_valid=1, hit_id=i, hit_flags[i]=1.
- hit_flags: set has priority over hit_clr on the same bit in the same cycle.
- ena low: state, idx, window, table, flags, counters hold. hit_valid forced 0. Pipelined det_cmp results in flight are not lost; evaluation resumes when ena returns.
- det_a/det_b in IDLE: window and table[0].pat (don't-care to array).
- Reset mid-scan: abort to IDLE. Window=0, all table entries pat=0/len=0 (all disabled), hit_flags=0, hit_valid=0, hit_id=0, idx=0.

## Timing
- Bit accepted at cycle T (IDLE). SCAN occupies T+1..T+NSLOT; slot i is presented at T+1+i.
- det_cmp for slot i arrives at T+2+i. hit_valid/hit_id for slot i are registered at T+3+i.
- DRAIN at T+NSLOT+1. IDLE and din_ready=1 again at T+NSLOT+2.
- Throughput: one bit per NSLOT+2 cycles (6 for NSLOT=4).
- A bit accepted at T+NSLOT+2 does not collide with the last hit_valid, which is registered at T+NSLOT+2.
- Window shift is visible on det_a from T+1.
- Reset values of outputs: din_ready=cfg_ready=ena, busy=0, hit_valid=0, hit_id=0, hit_flags=0, det_a=0, det_b=0.

## Configuration
- HIT_COUNT_EN defined: adds per-slot 8-bit saturating hit counters. Each counter increments on that slot's hit_valid and holds at 255. A counter clears when its hit_clr bit is high and no simultaneous hit occurs; a simultaneous hit sets it to 1.
- Adds ports cnt_sel (in, SW) and cnt_out (out, 8), where cnt_out = counter[cnt_sel] combinationally. Counters reset to 0.
- HIT_COUNT_EN undefined: no counters and no cnt_sel/cnt_out ports; all other behaviour is identical.

## Test plan
- Reset then idle: all outputs at reset values, busy=0. Feed a bit with all slots len=0 -> no hit_valid over 6 cycles; din_ready returns at T+6.
- Slot 2 pat=8'b0000_0101, len=3, model array as XNOR. Stream 1,0,1 -> on the third bit's scan, hit_valid=1, hit_id=2 at T+5; hit_flags=4'b0100.
- Slot 0 pat=8'hFF len=8 and slot 3 pat=8'h01 len=1. Eight 1s -> final bit gives hit_id=0 at T+3 and hit_id=3 at T+6; earlier bits give slot 3 only.
- hit_clr[2] asserted in the same cycle as a slot-2 hit -> flag stays 1. hit_clr[2] a cycle later -> flag 0.
- cfg_we during SCAN -> ignored (cfg_ready=0). ena low for 3 cycles mid-scan -> hit timing shifts by exactly 3 cycles and no pulse is lost.
- rst_n low at T+2 of a scan -> immediate reset values, table disabled, no hit_valid afterwards. With HIT_COUNT_EN: 300 hits on slot 1 -> cnt_out=255 for cnt_sel=1.
